mem_stage_sram_ctrl: RTL and testbench
======================================

Name: mem_stage_sram_ctrl

Overview:
- Memory-stage data-memory controller. It sits between the EX/MEM pipeline register and the MEM/WB register.
- Takes the ALU result as the byte address, plus the store value and the read/write enables.
- Performs a multi-cycle access to an external 32-bit-wide SRAM.
- Drives a `ready` signal that freezes the whole pipeline while the access is in flight.
- The read data and `ready` feed the MEM/WB register directly.

Parameters:
- WAIT_CYCLES, 4, number of cycles the SRAM is strobed per access. Legal range is 2..15.
- ADDR_BASE, 1024, byte address of data-memory word 0. It is subtracted before mapping.
- SRAM_ADDR_W, 17, width of the SRAM word address.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rd_en  in  1  memory-read request from EX/MEM.
- wr_en  in  1  memory-write request from EX/MEM.
- address  in  32  byte address (ALU result).
- st_val  in  32  store data.
- rd_data  out  32  registered load data to MEM/WB.
- ready  out  1  1 = pipeline may advance; 0 = freeze all pipeline registers and the PC.
- sram_addr  out  SRAM_ADDR_W  SRAM word address.
- sram_dq_out  out  32  write data to the pad.
- sram_dq_in  in  32  read data from the pad.
- sram_dq_oe  out  1  pad output enable (1 = drive sram_dq_out).
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.

Behaviour:
- Address map:
  - Word address = (address - ADDR_BASE) >> 2, truncated to SRAM_ADDR_W bits.
  - Out-of-range addresses wrap by truncation; no error is flagged.
- Request arbitration:
  - A request is present when rd_en | wr_en.
  - If both are asserted, the write wins and the read is dropped.
- State machine states: IDLE, ACCESS, DONE. A 4-bit down-counter `cnt` runs inside ACCESS.
- IDLE:
  - ready = !(rd_en | wr_en). The freeze is combinational in the same cycle the request appears.
  - On a request: latch the word address, st_val and the op (read/write). Load cnt = WAIT_CYCLES-1 and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - ready = 0 and sram_ce_n = 0.
  - Read op: sram_oe_n = 0 and sram_dq_oe = 0.
  - Write op: sram_dq_oe = 1 and sram_dq_out = latched st_val. sram_we_n = 0 while cnt != 0 and 1 when cnt == 0, which provides data hold on the final cycle.
  - cnt decrements each cycle. At cnt == 0 the next state is DONE.
  - For a read, rd_data <= sram_dq_in on that same edge.
- DONE:
  - ready = 1 and all SRAM strobes are deasserted.
  - Inputs are ignored, because EX/MEM still holds the finished instruction. The next state is IDLE unconditionally.
- Latency: a request seen in cycle t0 holds ready low for cycles t0..t0+WAIT_CYCLES. ready returns high in t0+WAIT_CYCLES+1 (DONE). The next instruction's request is sampled in t0+WAIT_CYCLES+2.
- sram_addr:
  - Driven from the latched address in ACCESS.
  - Holds its last value in IDLE/DONE (0 after reset).
- rd_data:
  - Updates only at completion of a read.
  - Writes and idle cycles leave it unchanged.
  - Back-to-back loads to different addresses each return their own word.
- Signals outside ACCESS: sram_ce_n = sram_oe_n = sram_we_n = 1 and sram_dq_oe = 0.
- Reset (rst = 0, asynchronous):
  - State IDLE, cnt = 0, rd_data = 0, latched address/data = 0, sram_addr = 0.
  - All strobes deassert immediately, even mid-access. The aborted access is discarded.
  - ready is forced to 1 while rst = 0.
  - After release, the first request follows the normal timing.

Test Plan:
- Reset mid-write: assert rst = 0 in the 2nd ACCESS cycle -> sram_we_n = 1, sram_dq_oe = 0 and ready = 1 within the same cycle. rd_data = 0. After release, the state is IDLE.
- Single load, WAIT_CYCLES = 4, address = 1032, model returns 0xDEADBEEF -> sram_addr = 2. ready is low for 5 cycles. rd_data = 0xDEADBEEF when ready rises. sram_oe_n is low for exactly 4 cycles.
- Single store, address = 1024, st_val = 0x12345678 -> sram_addr = 0. sram_we_n is low for 3 cycles, then high one cycle with data still driven. The SRAM model holds 0x12345678.
- Back-to-back store then load at the same address 1100 -> the load returns the stored value. ready gets exactly one high cycle (DONE) between the two freezes. The load's request is not serviced during DONE.
- Simultaneous rd_en = wr_en = 1 at address 1028 -> a write access is performed (sram_we_n pulses, sram_oe_n stays 1). rd_data is unchanged from its previous value.
- Idle with no request for 10 cycles -> ready = 1 throughout, all strobes high, and rd_data is stable.

Source files
------------

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage data-memory controller: turns one EX/MEM load/store into a
// multi-cycle strobed access on an external 32-bit SRAM and freezes the pipeline meanwhile.
module mem_stage_sram_ctrl #(
  parameter int          WAIT_CYCLES = 4,
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int          SRAM_ADDR_W = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            st_val,
  output logic [31:0]            rd_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [31:0]            sram_dq_out,
  input  logic [31:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  logic [31:0]            rd_data_q, rd_data_d;
  logic                   wr_op_q, wr_op_d;
  logic                   req;

  assign req = rd_en | wr_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      data_q    <= 32'd0;
      rd_data_q <= 32'd0;
      wr_op_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_data_q <= rd_data_d;
      wr_op_q   <= wr_op_d;
    end
  end

  // DONE never looks at the inputs: EX/MEM still holds the finished instruction.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A simultaneous read and write is treated as a write.
  always_comb begin
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_data_d = rd_data_q;
    wr_op_d   = wr_op_q;
    if (state_q == IDLE && req) begin
      cnt_d   = CNT_INIT;
      addr_d  = SRAM_ADDR_W'((address - ADDR_BASE) >> 2);
      data_d  = st_val;
      wr_op_d = wr_en;
    end else if (state_q == ACCESS) begin
      if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else if (!wr_op_q) begin
        rd_data_d = sram_dq_in;
      end
    end
  end

  // we_n rises on the last strobe cycle so the data is held past the write edge.
  always_comb begin
    ready      = 1'b1;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    unique case (state_q)
      IDLE:    ready = !req;
      ACCESS: begin
        ready     = 1'b0;
        sram_ce_n = 1'b0;
        if (wr_op_q) begin
          sram_dq_oe = 1'b1;
          sram_we_n  = (cnt_q == 4'd0);
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b1;
    endcase
    if (!rst) ready = 1'b1;
  end

  assign sram_addr   = addr_q;
  assign sram_dq_out = data_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench for mem_stage_sram_ctrl: stimulus queues hand-computed expectations,
// a negedge monitor measures each freeze and compares when ready returns high.
module tb_mem_stage_sram_ctrl;

  localparam int SRAM_ADDR_W = 17;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   rd_en = 1'b0;
  logic                   wr_en = 1'b0;
  logic [31:0]            address = 32'd0;
  logic [31:0]            st_val = 32'd0;
  logic [31:0]            rd_data;
  logic                   ready;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [31:0]            sram_dq_out;
  logic [31:0]            sram_dq_in;
  logic                   sram_dq_oe;
  logic                   sram_ce_n;
  logic                   sram_oe_n;
  logic                   sram_we_n;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [SRAM_ADDR_W-1:0] addr;
    logic                   is_wr;
    logic [31:0]            wdata;
    logic [31:0]            rd_data;
    int                     oe_cycles;
    int                     we_cycles;
    int                     hold_cycles;
    logic                   chk_gap;
  } exp_t;

  exp_t sb[$];

  logic [31:0] mem [0:255] = '{2: 32'hDEADBEEF, default: 32'h0};

  mem_stage_sram_ctrl #(
    .WAIT_CYCLES(4),
    .ADDR_BASE(32'd1024),
    .SRAM_ADDR_W(SRAM_ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .address(address),
    .st_val(st_val),
    .rd_data(rd_data),
    .ready(ready),
    .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model: reads while oe_n is low, captures writes on the clock.
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_out;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a freeze is a run of low-ready cycles; its end (DONE) pops one expectation.
  int   low_cnt = 0, oe_cnt = 0, we_cnt = 0, hold_cnt = 0, high_run = 0;
  logic in_frz = 1'b0;
  logic [SRAM_ADDR_W-1:0] addr_seen = '0;

  always @(negedge clk) begin
    if (!rst) begin
      in_frz   = 1'b0;
      high_run = 0;
    end else if (!ready) begin
      if (!in_frz) begin
        in_frz = 1'b1;
        low_cnt = 0; oe_cnt = 0; we_cnt = 0; hold_cnt = 0;
        if (sb.size() > 0 && sb[0].chk_gap) check_output("ready_gap_cycles", high_run, 1);
      end
      low_cnt++;
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) we_cnt++;
      if (!sram_ce_n) addr_seen = sram_addr;
      if (sb.size() > 0 && !sram_ce_n && sram_we_n && sram_dq_oe && sram_dq_out == sb[0].wdata)
        hold_cnt++;
    end else begin
      if (in_frz) begin
        exp_t it;
        in_frz   = 1'b0;
        high_run = 0;
        if (sb.size() == 0) begin
          check_output("unexpected_completion", 32'd1, 32'd0);
        end else begin
          it = sb.pop_front();
          check_output("ready_low_cycles", low_cnt, 5);
          check_output("sram_addr", 32'(addr_seen), 32'(it.addr));
          check_output("oe_low_cycles", oe_cnt, it.oe_cycles);
          check_output("we_low_cycles", we_cnt, it.we_cycles);
          check_output("write_hold_cycles", hold_cnt, it.hold_cycles);
          check_output("rd_data", rd_data, it.rd_data);
          check_output("done_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'b1110);
          if (it.is_wr) check_output("mem_word", mem[it.addr[7:0]], it.wdata);
        end
      end
      high_run++;
    end
  end

  // Drives one request at posedge+1 and returns in its DONE cycle.
  task automatic apply_stimulus(input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] st, input logic [SRAM_ADDR_W-1:0] exp_addr,
                                input logic [31:0] exp_rd, input logic gap);
    exp_t it;
    it.addr        = exp_addr;
    it.is_wr       = w;
    it.wdata       = st;
    it.rd_data     = exp_rd;
    it.oe_cycles   = w ? 0 : 4;
    it.we_cycles   = w ? 3 : 0;
    it.hold_cycles = w ? 1 : 0;
    it.chk_gap     = gap;
    sb.push_back(it);
    rd_en = r; wr_en = w; address = a; st_val = st;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready) return;
    end
    check_output("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic go_idle();
    rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; st_val = 32'd0;
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_ready", ready, 1);
    check_output("reset_rd_data", rd_data, 32'd0);
    check_output("reset_sram_addr", 32'(sram_addr), 32'd0);
    check_output("reset_strobes", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'b1110);
    @(posedge clk); #1;
    rst = 1'b1;

    // Reset asserted in the second write-strobe cycle aborts the access.
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b1; address = 32'd1024; st_val = 32'hAAAA5555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("midwrite_we_low", sram_we_n, 0);
    rst = 1'b0;
    #1;
    check_output("abort_we_n", sram_we_n, 1);
    check_output("abort_dq_oe", sram_dq_oe, 0);
    check_output("abort_ready", ready, 1);
    check_output("abort_rd_data", rd_data, 32'd0);
    go_idle();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_output("post_abort_idle", {27'd0, ready, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'b11110);

    apply_stimulus(1'b1, 1'b0, 32'd1032, 32'd0, 17'd2, 32'hDEADBEEF, 1'b0);
    go_idle();
    @(posedge clk); #1;
    apply_stimulus(1'b0, 1'b1, 32'd1024, 32'h12345678, 17'd0, 32'hDEADBEEF, 1'b0);
    go_idle();
    @(posedge clk); #1;
    apply_stimulus(1'b0, 1'b1, 32'd1100, 32'hCAFEF00D, 17'd19, 32'hDEADBEEF, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'd1100, 32'd0, 17'd19, 32'hCAFEF00D, 1'b1);
    go_idle();
    @(posedge clk); #1;
    apply_stimulus(1'b1, 1'b1, 32'd1028, 32'h0BADC0DE, 17'd1, 32'hCAFEF00D, 1'b0);
    go_idle();
    @(posedge clk); #1;
    apply_stimulus(1'b1, 1'b0, 32'd1028, 32'd0, 17'd1, 32'h0BADC0DE, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'd1032, 32'd0, 17'd2, 32'hDEADBEEF, 1'b1);
    go_idle();

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_output("idle_outputs", {27'd0, ready, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'b11110);
      check_output("idle_rd_data", rd_data, 32'hDEADBEEF);
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    check_output("scoreboard_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
